// File: rtl/kbd_sequencer_if.sv
// Signal bundle between the PS/2 byte receiver, the scan-code translator,
// the CPU-side keyboard registers and the keyboard sequencer.
interface kbd_sequencer_if;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       xl_shift;
    logic [7:0] xl_incode;
    logic [6:0] xl_ascii;
    logic       xl_ar2;
    logic [6:0] key_data;
    logic       key_ready;
    logic       key_down;
    logic       vec274;
    logic       irq;
    logic       irq_dis;
    logic       rd_ack;

    // Sequencer side.
    modport master (
        input  scan_valid, scan_code, xl_ascii, xl_ar2, irq_dis, rd_ack,
        output xl_shift, xl_incode, key_data, key_ready, key_down, vec274, irq
    );

    // Environment side: receiver, translator and CPU registers.
    modport slave (
        output scan_valid, scan_code, xl_ascii, xl_ar2, irq_dis, rd_ack,
        input  xl_shift, xl_incode, key_data, key_ready, key_down, vec274, irq
    );
endinterface

// File: rtl/kbd_sequencer.sv
// PS/2 scan-code sequencer: parses break/extended prefixes, tracks the shift
// keys, suppresses typematic repeats, runs one lookup cycle through an
// external translator and latches the resulting key code for the CPU.
module kbd_sequencer #(
    parameter logic [7:0] BREAK_PFX = 8'hF0,
    parameter logic [7:0] EXT_PFX   = 8'hE0,
    parameter logic [7:0] LSHIFT    = 8'h12,
    parameter logic [7:0] RSHIFT    = 8'h59
) (
    input  logic            clk,
    input  logic            reset_n,
    kbd_sequencer_if.master kbd
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BRK    = 3'd1,
        S_EXT    = 3'd2,
        S_EXTBRK = 3'd3,
        S_LOOKUP = 3'd4
    } state_t;

    state_t     state, state_next;

    logic       lflag, lflag_next;
    logic       rflag, rflag_next;
    logic [7:0] incode_r, incode_next;
    logic [7:0] held_r, held_next;
    logic [6:0] key_data_r, key_data_next;
    logic       key_ready_r, key_ready_next;
    logic       key_down_r, key_down_next;
    logic       vec274_r, vec274_next;
    logic       ar2_pend, ar2_pend_next;

    logic       skid_valid;
    logic [7:0] skid_code;

    logic       parsing;
    logic       byte_valid;
    logic [7:0] byte_code;
    logic       is_shift_code;
    logic       do_make;
    logic       do_break;
    logic       is_ext;

    // Prefix/byte states consume input; LOOKUP only parks bytes in the skid.
    assign parsing = (state == S_IDLE) || (state == S_BRK) ||
                     (state == S_EXT)  || (state == S_EXTBRK);

    // Select the byte to parse this cycle: a parked skid byte wins, and a new
    // strobe arriving alongside it is lost.
    always_comb begin
        byte_valid = 1'b0;
        byte_code  = kbd.scan_code;
        if (parsing) begin
            if (skid_valid) begin
                byte_valid = 1'b1;
                byte_code  = skid_code;
            end else if (kbd.scan_valid) begin
                byte_valid = 1'b1;
            end
        end
    end

    assign is_shift_code = (byte_code == LSHIFT) || (byte_code == RSHIFT);

    // Next-state and next-register decode for the parser and lookup stage.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next    = state;
        lflag_next    = lflag;
        rflag_next    = rflag;
        incode_next   = incode_r;
        held_next     = held_r;
        key_data_next = key_data_r;
        key_down_next = key_down_r;
        vec274_next   = vec274_r;
        ar2_pend_next = ar2_pend;
        // NOTE: blocking assignments in combinational logic; the lookup branch
        // below reads key_ready_next after the rd_ack clear has been applied.
        key_ready_next = key_ready_r & ~kbd.rd_ack;
        do_make  = 1'b0;
        do_break = 1'b0;
        is_ext   = 1'b0;

        case (state)
            S_IDLE: begin
                if (byte_valid) begin
                    if (byte_code == BREAK_PFX) begin
                        state_next = S_BRK;
                    end else if (byte_code == EXT_PFX) begin
                        state_next = S_EXT;
                    end else begin
                        do_make = 1'b1;
                    end
                end
            end
            S_EXT: begin
                if (byte_valid) begin
                    if (byte_code == BREAK_PFX) begin
                        state_next = S_EXTBRK;
                    end else begin
                        do_make = 1'b1;
                        is_ext  = 1'b1;
                    end
                end
            end
            S_BRK: begin
                if (byte_valid) begin
                    do_break = 1'b1;
                end
            end
            S_EXTBRK: begin
                if (byte_valid) begin
                    do_break = 1'b1;
                    is_ext   = 1'b1;
                end
            end
            S_LOOKUP: begin
                state_next = S_IDLE;
                if (kbd.xl_ar2) begin
                    // Prefix key: remember that the next key uses vector 274.
                    ar2_pend_next = 1'b1;
                end else if ((kbd.xl_ascii != 7'h00) && !key_ready_next) begin
                    key_data_next  = kbd.xl_ascii;
                    key_ready_next = 1'b1;
                    vec274_next    = ar2_pend;
                    ar2_pend_next  = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (do_make) begin
            state_next = S_IDLE;
            if (is_shift_code) begin
                // Extended 12/59 are fake shifts inserted by the keyboard.
                if (!is_ext) begin
                    if (byte_code == LSHIFT) begin
                        lflag_next = 1'b1;
                    end else begin
                        rflag_next = 1'b1;
                    end
                end
            end else if (!(key_down_r && (byte_code == held_r))) begin
                incode_next   = byte_code;
                held_next     = byte_code;
                key_down_next = 1'b1;
                state_next    = S_LOOKUP;
            end
        end

        if (do_break) begin
            state_next = S_IDLE;
            if (is_shift_code) begin
                if (!is_ext) begin
                    if (byte_code == LSHIFT) begin
                        lflag_next = 1'b0;
                    end else begin
                        rflag_next = 1'b0;
                    end
                end
            end else if (byte_code == held_r) begin
                key_down_next = 1'b0;
            end
        end
    end

    // Parser state and key registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            lflag       <= 1'b0;
            rflag       <= 1'b0;
            incode_r    <= 8'h00;
            held_r      <= 8'h00;
            key_data_r  <= 7'h00;
            key_ready_r <= 1'b0;
            key_down_r  <= 1'b0;
            vec274_r    <= 1'b0;
            ar2_pend    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all sequential state, so
            // every register samples pre-edge values regardless of order.
            state       <= state_next;
            lflag       <= lflag_next;
            rflag       <= rflag_next;
            incode_r    <= incode_next;
            held_r      <= held_next;
            key_data_r  <= key_data_next;
            key_ready_r <= key_ready_next;
            key_down_r  <= key_down_next;
            vec274_r    <= vec274_next;
            ar2_pend    <= ar2_pend_next;
        end
    end

    // Skid occupancy: fill on a strobe during LOOKUP, drain in any parsing state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid <= 1'b0;
        end else if (state == S_LOOKUP) begin
            if (kbd.scan_valid && !skid_valid) begin
                skid_valid <= 1'b1;
            end
        end else if (parsing) begin
            skid_valid <= 1'b0;
        end
    end

    // Skid data byte, captured alongside the occupancy flag.
    always_ff @(posedge clk) begin
        // NOTE: the skid data is not reset; it is only ever read while
        // skid_valid is set, and skid_valid is reset.
        if ((state == S_LOOKUP) && kbd.scan_valid && !skid_valid) begin
            skid_code <= kbd.scan_code;
        end
    end

    assign kbd.xl_shift  = lflag | rflag;
    assign kbd.xl_incode = incode_r;
    assign kbd.key_data  = key_data_r;
    assign kbd.key_ready = key_ready_r;
    assign kbd.key_down  = key_down_r;
    assign kbd.vec274    = vec274_r;
    assign kbd.irq       = key_ready_r & ~kbd.irq_dis;

endmodule

// File: tb/tb_kbd_sequencer.sv
// Directed bench for kbd_sequencer with a small scan-code translator model.
module tb_kbd_sequencer;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    kbd_sequencer_if kbd ();

    kbd_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kbd     (kbd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Translator model: set-2 codes to BK key codes, shift-aware.
    always_comb begin
        kbd.xl_ascii = 7'h00;
        kbd.xl_ar2   = 1'b0;
        case (kbd.xl_incode)
            8'h1C:   kbd.xl_ascii = kbd.xl_shift ? 7'h41 : 7'h61;
            8'h32:   kbd.xl_ascii = kbd.xl_shift ? 7'h42 : 7'h62;
            8'h1B:   kbd.xl_ascii = kbd.xl_shift ? 7'h53 : 7'h73;
            8'h16:   kbd.xl_ascii = kbd.xl_shift ? 7'h21 : 7'h31;
            8'h75:   kbd.xl_ascii = 7'o032;
            8'h05:   kbd.xl_ar2   = 1'b1;
            default: kbd.xl_ascii = 7'h00;
        endcase
    end

    task automatic send(input logic [7:0] code);
        @(negedge clk);
        kbd.scan_valid = 1'b1;
        kbd.scan_code  = code;
        @(negedge clk);
        kbd.scan_valid = 1'b0;
    endtask

    task automatic rd();
        @(negedge clk);
        kbd.rd_ack = 1'b1;
        @(negedge clk);
        kbd.rd_ack = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({kbd.xl_shift, kbd.xl_incode, kbd.key_data, kbd.key_ready, kbd.key_down,
             kbd.vec274, kbd.irq} !== 20'h0) begin
            miscompares++;
            $display("FAIL %s: outputs %b, expected all zero", tag,
                     {kbd.xl_shift, kbd.xl_incode, kbd.key_data, kbd.key_ready,
                      kbd.key_down, kbd.vec274, kbd.irq});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        pulse_reset("reset_outputs");
    endtask

    task automatic test_basic();
        send(8'h1C);
        vectors++;
        if ({kbd.key_ready, kbd.key_down, kbd.xl_incode} !== {1'b0, 1'b1, 8'h1C}) begin
            miscompares++;
            $display("FAIL basic_lookup: ready/down/incode %b/%b/%h, expected 0/1/1c",
                     kbd.key_ready, kbd.key_down, kbd.xl_incode);
        end
        @(negedge clk);
        vectors++;
        if ({kbd.key_ready, kbd.key_data, kbd.irq, kbd.vec274} !== {1'b1, 7'h61, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_deliver: ready/data/irq/vec %b/%h/%b/%b, expected 1/61/1/0",
                     kbd.key_ready, kbd.key_data, kbd.irq, kbd.vec274);
        end
        send(8'hF0);
        send(8'h1C);
        vectors++;
        if ({kbd.key_down, kbd.key_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL basic_break: down/ready %b/%b, expected 0/1", kbd.key_down, kbd.key_ready);
        end
        rd();
        vectors++;
        if ({kbd.key_ready, kbd.irq} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_ack: ready/irq %b/%b, expected 0/0", kbd.key_ready, kbd.irq);
        end
    endtask

    task automatic test_shift();
        send(8'h12);
        vectors++;
        if (kbd.xl_shift !== 1'b1) begin
            miscompares++;
            $display("FAIL shift_make: xl_shift %b, expected 1", kbd.xl_shift);
        end
        send(8'h1C);
        vectors++;
        if ({kbd.xl_shift, kbd.xl_incode} !== {1'b1, 8'h1C}) begin
            miscompares++;
            $display("FAIL shift_lookup: shift/incode %b/%h, expected 1/1c", kbd.xl_shift, kbd.xl_incode);
        end
        @(negedge clk);
        vectors++;
        if ({kbd.key_ready, kbd.key_data} !== {1'b1, 7'h41}) begin
            miscompares++;
            $display("FAIL shift_deliver: ready/data %b/%h, expected 1/41", kbd.key_ready, kbd.key_data);
        end
        send(8'hF0);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        vectors++;
        if ({kbd.xl_shift, kbd.key_down} !== 2'b00) begin
            miscompares++;
            $display("FAIL shift_break: shift/down %b/%b, expected 0/0", kbd.xl_shift, kbd.key_down);
        end
        send(8'h59);
        vectors++;
        if (kbd.xl_shift !== 1'b1) begin
            miscompares++;
            $display("FAIL rshift_make: xl_shift %b, expected 1", kbd.xl_shift);
        end
        send(8'hF0);
        send(8'h59);
        vectors++;
        if (kbd.xl_shift !== 1'b0) begin
            miscompares++;
            $display("FAIL rshift_break: xl_shift %b, expected 0", kbd.xl_shift);
        end
        rd();
    endtask

    task automatic test_ar2();
        send(8'h05);
        @(negedge clk);
        vectors++;
        if ({kbd.key_ready, kbd.vec274} !== 2'b00) begin
            miscompares++;
            $display("FAIL ar2_prefix: ready/vec %b/%b, expected 0/0", kbd.key_ready, kbd.vec274);
        end
        send(8'h16);
        @(negedge clk);
        vectors++;
        if ({kbd.key_ready, kbd.key_data, kbd.vec274} !== {1'b1, 7'h31, 1'b1}) begin
            miscompares++;
            $display("FAIL ar2_deliver: ready/data/vec %b/%h/%b, expected 1/31/1",
                     kbd.key_ready, kbd.key_data, kbd.vec274);
        end
        rd();
        send(8'h1C);
        @(negedge clk);
        vectors++;
        if ({kbd.key_ready, kbd.key_data, kbd.vec274} !== {1'b1, 7'h61, 1'b0}) begin
            miscompares++;
            $display("FAIL ar2_next: ready/data/vec %b/%h/%b, expected 1/61/0",
                     kbd.key_ready, kbd.key_data, kbd.vec274);
        end
        rd();
        send(8'hF0);
        send(8'h1C);
    endtask

    task automatic test_typematic();
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        send(8'h32);
        @(negedge clk);
        vectors++;
        if ({kbd.key_ready, kbd.key_data, kbd.xl_incode} !== {1'b1, 7'h61, 8'h32}) begin
            miscompares++;
            $display("FAIL drop_busy: ready/data/incode %b/%h/%h, expected 1/61/32",
                     kbd.key_ready, kbd.key_data, kbd.xl_incode);
        end
        rd();
        send(8'h32);
        @(negedge clk);
        vectors++;
        if (kbd.key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL repeat_discard: ready %b, expected 0", kbd.key_ready);
        end
        send(8'h1C);
        @(negedge clk);
        // Next make's LOOKUP cycle coincides with the CPU read.
        @(negedge clk);
        kbd.scan_valid = 1'b1;
        kbd.scan_code  = 8'h1B;
        @(negedge clk);
        kbd.scan_valid = 1'b0;
        kbd.rd_ack     = 1'b1;
        @(negedge clk);
        kbd.rd_ack = 1'b0;
        vectors++;
        if ({kbd.key_ready, kbd.key_data} !== {1'b1, 7'h73}) begin
            miscompares++;
            $display("FAIL ack_coincident: ready/data %b/%h, expected 1/73", kbd.key_ready, kbd.key_data);
        end
        rd();
        send(8'hF0);
        send(8'h1B);
        vectors++;
        if (kbd.key_down !== 1'b0) begin
            miscompares++;
            $display("FAIL typematic_release: down %b, expected 0", kbd.key_down);
        end
    endtask

    task automatic test_ext();
        send(8'hE0);
        send(8'h75);
        @(negedge clk);
        vectors++;
        if ({kbd.key_ready, kbd.key_data, kbd.key_down} !== {1'b1, 7'o032, 1'b1}) begin
            miscompares++;
            $display("FAIL ext_deliver: ready/data/down %b/%o/%b, expected 1/032/1",
                     kbd.key_ready, kbd.key_data, kbd.key_down);
        end
        kbd.irq_dis = 1'b1;
        #1;
        vectors++;
        if (kbd.irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_disabled: irq %b, expected 0", kbd.irq);
        end
        kbd.irq_dis = 1'b0;
        #1;
        vectors++;
        if (kbd.irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_enabled: irq %b, expected 1", kbd.irq);
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        vectors++;
        if (kbd.key_down !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_break: down %b, expected 0", kbd.key_down);
        end
        rd();
        send(8'hE0);
        send(8'h12);
        vectors++;
        if ({kbd.xl_shift, kbd.key_down, kbd.xl_incode} !== {1'b0, 1'b0, 8'h75}) begin
            miscompares++;
            $display("FAIL fake_shift_make: shift/down/incode %b/%b/%h, expected 0/0/75",
                     kbd.xl_shift, kbd.key_down, kbd.xl_incode);
        end
        send(8'h12);
        send(8'hE0);
        send(8'hF0);
        send(8'h12);
        vectors++;
        if (kbd.xl_shift !== 1'b1) begin
            miscompares++;
            $display("FAIL fake_shift_break: xl_shift %b, expected 1", kbd.xl_shift);
        end
        send(8'hF0);
        send(8'h12);
        send(8'h58);
        @(negedge clk);
        vectors++;
        if ({kbd.xl_shift, kbd.key_ready, kbd.key_down} !== 3'b001) begin
            miscompares++;
            $display("FAIL null_code: shift/ready/down %b/%b/%b, expected 0/0/1",
                     kbd.xl_shift, kbd.key_ready, kbd.key_down);
        end
        send(8'hF0);
        send(8'h58);
    endtask

    task automatic test_back_to_back();
        send(8'hF0);
        pulse_reset("reset_after_prefix");
        send(8'h1C);
        @(negedge clk);
        vectors++;
        if ({kbd.key_ready, kbd.key_data} !== {1'b1, 7'h61}) begin
            miscompares++;
            $display("FAIL prefix_discarded: ready/data %b/%h, expected 1/61", kbd.key_ready, kbd.key_data);
        end
        pulse_reset("reset_between_bytes");
        // 1C, then 32 during LOOKUP (skid), then 1B while the skid is full.
        @(negedge clk);
        kbd.scan_valid = 1'b1;
        kbd.scan_code  = 8'h1C;
        @(negedge clk);
        kbd.scan_code  = 8'h32;
        @(negedge clk);
        kbd.scan_code  = 8'h1B;
        kbd.rd_ack     = 1'b1;
        @(negedge clk);
        kbd.scan_valid = 1'b0;
        kbd.rd_ack     = 1'b0;
        vectors++;
        if ({kbd.key_ready, kbd.xl_incode} !== {1'b0, 8'h32}) begin
            miscompares++;
            $display("FAIL skid_lookup: ready/incode %b/%h, expected 0/32", kbd.key_ready, kbd.xl_incode);
        end
        @(negedge clk);
        vectors++;
        if ({kbd.key_ready, kbd.key_data, kbd.xl_incode} !== {1'b1, 7'h62, 8'h32}) begin
            miscompares++;
            $display("FAIL skid_deliver: ready/data/incode %b/%h/%h, expected 1/62/32",
                     kbd.key_ready, kbd.key_data, kbd.xl_incode);
        end
        rd();
        // 1C, F0 parked in the skid, idle cycle, then 1C completes the break.
        @(negedge clk);
        kbd.scan_valid = 1'b1;
        kbd.scan_code  = 8'h1C;
        @(negedge clk);
        kbd.scan_code  = 8'hF0;
        @(negedge clk);
        kbd.scan_valid = 1'b0;
        @(negedge clk);
        kbd.scan_valid = 1'b1;
        kbd.scan_code  = 8'h1C;
        @(negedge clk);
        kbd.scan_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({kbd.key_down, kbd.key_ready, kbd.key_data} !== {1'b0, 1'b1, 7'h61}) begin
            miscompares++;
            $display("FAIL skid_once: down/ready/data %b/%b/%h, expected 0/1/61",
                     kbd.key_down, kbd.key_ready, kbd.key_data);
        end
        rd();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset_n        = 1'b0;
        kbd.scan_valid = 1'b0;
        kbd.scan_code  = 8'h00;
        kbd.irq_dis    = 1'b0;
        kbd.rd_ack     = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_basic();
        test_shift();
        test_ar2();
        test_typematic();
        test_ext();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kbd_sequencer.md
KBD_SEQUENCER -- requirements
Module: kbd_sequencer

Interface
REQ-001 Parameter: BREAK_PFX, 8'hF0, PS/2 break prefix.
REQ-002 Parameter: EXT_PFX, 8'hE0, PS/2 extended prefix.
REQ-003 Parameter: LSHIFT, 8'h12, left-shift scan code.
REQ-004 Parameter: RSHIFT, 8'h59, right-shift scan code.
REQ-005 Port: clk  in  1  sole clock; all state on rising edge.
REQ-006 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port: scan_valid  in  1  one-cycle strobe, new byte from PS/2 receiver.
REQ-008 Port: scan_code  in  8  received byte, valid with scan_valid.
REQ-009 Port: xl_shift  out  1  shift input to translator.
REQ-010 Port: xl_incode  out  8  registered scan code to translator.
REQ-011 Port: xl_ascii  in  7  translator output, combinational from xl_shift/xl_incode.
REQ-012 Port: xl_ar2  in  1  translator AR2 (POVT) flag.
REQ-013 Port: key_data  out  7  latched BK key code.
REQ-014 Port: key_ready  out  1  data-ready status bit.
REQ-015 Port: key_down  out  1  non-shift key held.
REQ-016 Port: vec274  out  1  1 = current key uses vector 274 (AR2), 0 = vector 060.
REQ-017 Port: irq  out  1  interrupt request, level.
REQ-018 Port: irq_dis  in  1  interrupt disable from status register.
REQ-019 Port: rd_ack  in  1  one-cycle strobe, CPU read of data register.

Function
REQ-020 FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXTBRK (E0 F0 seen), LOOKUP.
REQ-021 IDLE: F0 -> BRK; E0 -> EXT; other byte -> make handling.
REQ-022 EXT: F0 -> EXTBRK; other byte -> make handling. Extended codes are treated as their non-extended equivalents, except E0 12 / E0 59 (fake shifts), which are ignored.
REQ-023 BRK and EXTBRK: next byte -> break handling, then IDLE.
REQ-024 Make of LSHIFT/RSHIFT sets its flag. Break clears it. xl_shift = lflag OR rflag. No delivery, no state change beyond IDLE.
REQ-025 Other make: if code equals held-key register and key_down=1 -> typematic repeat, discarded.
REQ-026 Other make, not a repeat: xl_incode <= code, held <= code, key_down <= 1, state -> LOOKUP.
REQ-027 LOOKUP lasts exactly one cycle; xl_ascii/xl_ar2 are sampled in it; state -> IDLE.
REQ-028 In LOOKUP, xl_ar2=1: ar2_pend <= 1, no delivery.
REQ-029 In LOOKUP, xl_ascii=0 and xl_ar2=0: discarded.
REQ-030 In LOOKUP, xl_ascii!=0: deliver if key_ready=0 after rd_ack is applied. Delivery sets key_data <= xl_ascii, key_ready <= 1, vec274 <= ar2_pend, ar2_pend <= 0.
REQ-031 Delivery while key_ready=1 and no rd_ack: code dropped; key_data, vec274 and ar2_pend unchanged.
REQ-032 Latency: make byte strobe at cycle N -> LOOKUP at N+1 -> key_ready high at N+2.
REQ-033 Break of code equal to held: key_down <= 0. Break of any other code: no effect.
REQ-034 rd_ack clears key_ready. If rd_ack and delivery occur in the same cycle, key_ready stays 1 with the new key_data.
REQ-035 irq = key_ready AND NOT irq_dis, combinational from registers.
REQ-036 A scan_valid arriving in LOOKUP is held in a 1-entry skid register and processed in the following IDLE cycle. A second byte arriving while the skid register is full is dropped.
REQ-037 Unknown state encodings -> IDLE.

Reset
REQ-038 reset_n low asynchronously forces: state IDLE, shift flags 0, xl_incode 8'h00, held 8'h00, key_data 7'h00, key_ready 0, key_down 0, vec274 0, ar2_pend 0, skid empty. irq therefore 0.
REQ-039 Reset mid-sequence (e.g. after F0) discards the prefix; the first byte after release is parsed from IDLE.

Verification
REQ-040 Scenario: bytes 1C then F0 1C, with translator model -> key_data 7'h61, key_ready=1 at N+2, key_down 1 then 0, irq=1.
REQ-041 Scenario: 12, 1C, F0 1C, F0 12 -> xl_shift=1 during lookup, key_data 7'h41; xl_shift=0 after shift break.
REQ-042 Scenario: 05 then 16 -> first byte gives no delivery; second gives key_data 7'h31 with vec274=1. Next key delivers with vec274=0.
REQ-043 Scenario: 1C, 1C, 1C (typematic) -> single delivery. Then 32 with no rd_ack -> dropped, key_data stays 7'h61. rd_ack coincident with a later delivery -> key_ready stays 1 with new data.
REQ-044 Scenario: E0 75 -> key_data 8'o032. E0 12 -> ignored, xl_shift unchanged. irq_dis=1 -> irq=0 while key_ready=1.
REQ-045 Scenario: reset_n pulsed low after F0 and between bytes; byte arrival back-to-back during LOOKUP -> all outputs at reset values; the skid byte is processed exactly once.
